// File: rtl/serial_pattern_gen_if.sv
// Handshake and data bundle between a frame controller and serial_pattern_gen.
// master drives the job request and bit-time strobe; slave returns the serial line and status.
interface serial_pattern_gen_if #(
   parameter int WIDTH = 6,
   parameter int REP_W = 4
);
   logic             clk_en;
   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [REP_W-1:0] reps;
   logic             out;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output clk_en, start, pattern, reps,
      input  out, valid, busy, done
   );

   modport slave (
      input  clk_en, start, pattern, reps,
      output out, valid, busy, done
   );
endinterface

// File: rtl/serial_pattern_gen.sv
// MSB-first serial frame transmitter with repeat count and inter-frame gaps.
// Optional trailing even-parity bit per frame when PATTERN_GEN_PARITY_EN is defined.
module serial_pattern_gen #(
   parameter int               WIDTH           = 6,
   parameter int               GAP             = 2,
   parameter int               REP_W           = 4,
   parameter logic [WIDTH-1:0] DEFAULT_PATTERN = 6'b101100
) (
   input logic               clk,
   input logic               reset,
   serial_pattern_gen_if.slave bus
);

   localparam int BCW = $clog2(WIDTH);
   localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_GAP    = 3'd2,
`ifdef PATTERN_GEN_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_DONE   = 3'd3
   } state_t;

`ifdef PATTERN_GEN_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction
`endif

   state_t           state_r,   state_s;
   logic [WIDTH-1:0] shift_r,   shift_s;
   logic [WIDTH-1:0] latched_r, latched_s;
   logic [BCW-1:0]   bit_cnt_r, bit_cnt_s;
   logic [GCW-1:0]   gap_cnt_r, gap_cnt_s;
   logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
   state_t           eof_state_s;
   logic [REP_W-1:0] eof_rep_s;
   logic             out_r,   out_s;
   logic             valid_r, valid_s;
   logic             busy_r,  busy_s;
   logic             done_r,  done_s;

   // End-of-frame decision: another repetition (via gap or straight back) or finish.
   always_comb begin
      eof_state_s = ST_DONE;
      eof_rep_s   = rep_cnt_r;
      if (rep_cnt_r > REP_W'(1)) begin
         eof_rep_s   = rep_cnt_r - REP_W'(1);
         eof_state_s = (GAP > 0) ? ST_GAP : ST_SHIFT;
      end else begin
         eof_rep_s   = rep_cnt_r;
         eof_state_s = ST_DONE;
      end
   end

   // Next-state and datapath update for the transmit sequencer.
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      latched_s = latched_r;
      bit_cnt_s = bit_cnt_r;
      gap_cnt_s = gap_cnt_r;
      rep_cnt_s = rep_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               shift_s   = bus.pattern;
               latched_s = bus.pattern;
               bit_cnt_s = {BCW{1'b0}};
               gap_cnt_s = {GCW{1'b0}};
               rep_cnt_s = (bus.reps == {REP_W{1'b0}}) ? REP_W'(1) : bus.reps;
               state_s   = ST_SHIFT;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bus.clk_en) begin
               if (bit_cnt_r < BCW'(WIDTH - 1)) begin
                  shift_s   = {shift_r[WIDTH-2:0], 1'b0};
                  bit_cnt_s = bit_cnt_r + BCW'(1);
               end else begin
`ifdef PATTERN_GEN_PARITY_EN
                  state_s   = ST_PARITY;
`else
                  // Reloading here is harmless when heading to GAP or DONE.
                  shift_s   = latched_r;
                  bit_cnt_s = {BCW{1'b0}};
                  gap_cnt_s = {GCW{1'b0}};
                  rep_cnt_s = eof_rep_s;
                  state_s   = eof_state_s;
`endif
               end
            end else begin
               state_s = ST_SHIFT;
            end
         end
`ifdef PATTERN_GEN_PARITY_EN
         ST_PARITY: begin
            if (bus.clk_en) begin
               shift_s   = latched_r;
               bit_cnt_s = {BCW{1'b0}};
               gap_cnt_s = {GCW{1'b0}};
               rep_cnt_s = eof_rep_s;
               state_s   = eof_state_s;
            end else begin
               state_s = ST_PARITY;
            end
         end
`endif
         ST_GAP: begin
            if (bus.clk_en) begin
               if (gap_cnt_r == GCW'((GAP > 0) ? (GAP - 1) : 0)) begin
                  shift_s   = latched_r;
                  bit_cnt_s = {BCW{1'b0}};
                  gap_cnt_s = {GCW{1'b0}};
                  state_s   = ST_SHIFT;
               end else begin
                  gap_cnt_s = gap_cnt_r + GCW'(1);
               end
            end else begin
               state_s = ST_GAP;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so they can be registered.
   always_comb begin
      out_s   = 1'b0;
      valid_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_s)
         ST_IDLE: begin
            out_s = 1'b0;
         end
         ST_SHIFT: begin
            out_s   = shift_s[WIDTH-1];
            valid_s = 1'b1;
            busy_s  = 1'b1;
         end
`ifdef PATTERN_GEN_PARITY_EN
         ST_PARITY: begin
            out_s   = even_parity(latched_s);
            valid_s = 1'b1;
            busy_s  = 1'b1;
         end
`endif
         ST_GAP: begin
            busy_s = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            out_s = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         shift_r   <= DEFAULT_PATTERN;
         latched_r <= DEFAULT_PATTERN;
         bit_cnt_r <= {BCW{1'b0}};
         gap_cnt_r <= {GCW{1'b0}};
         rep_cnt_r <= {REP_W{1'b0}};
         out_r     <= 1'b0;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         latched_r <= latched_s;
         bit_cnt_r <= bit_cnt_s;
         gap_cnt_r <= gap_cnt_s;
         rep_cnt_r <= rep_cnt_s;
         out_r     <= out_s;
         valid_r   <= valid_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign bus.out   = out_r;
   assign bus.valid = valid_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: symbol-queue model checked every cycle plus literal job checks.
// Honours PATTERN_GEN_PARITY_EN the same way as the design.
module tb_serial_pattern_gen;
   localparam int WIDTH = 6;
   localparam int GAP   = 2;
   localparam int REP_W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   serial_pattern_gen_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

   serial_pattern_gen #(
      .WIDTH(WIDTH), .GAP(GAP), .REP_W(REP_W), .DEFAULT_PATTERN(6'b101100)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int en_div = 0;

   // Model: each accepted job becomes a queue of {out,valid} symbols, one per clk_en strobe.
   logic [1:0] mq[$];
   bit m_active = 1'b0;
   bit m_done   = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            mq.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (m_active) begin
            if (bus.clk_en) begin
               void'(mq.pop_front());
               if (mq.size() == 0) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
               end
            end
         end else if (bus.start) begin
            int n;
            logic [WIDTH-1:0] p;
            p = bus.pattern;
            n = (bus.reps == 0) ? 1 : int'(bus.reps);
            for (int f = 0; f < n; f++) begin
               for (int b = WIDTH - 1; b >= 0; b--) mq.push_back({p[b], 1'b1});
`ifdef PATTERN_GEN_PARITY_EN
               mq.push_back({^p, 1'b1});
`endif
               if (f < n - 1) for (int g = 0; g < GAP; g++) mq.push_back(2'b00);
            end
            m_active = 1'b1;
         end
      end
   end

   // Per-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            logic [3:0] e;
            e = {m_active ? mq[0][1] : 1'b0, m_active ? mq[0][0] : 1'b0, m_active, m_done};
            check("cycle_out_valid_busy_done", {60'd0, bus.out, bus.valid, bus.busy, bus.done}, {60'd0, e});
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (en_div > 0) bus.clk_en = ((cyc % en_div) == 0);
      else            bus.clk_en = 1'b1;
   endtask

   // Launch one job and record what the line carried until done, plus a short tail.
   task automatic run_job(input logic [5:0] pat, input logic [3:0] r, input bit en_only,
                          output logic [63:0] bits, output int nv, output int nb,
                          output int nd, output int dc);
      int c;
      bit fin;
      bits = 64'd0; nv = 0; nb = 0; nd = 0; dc = 0; fin = 1'b0; c = 1;
      bus.pattern = pat;
      bus.reps    = r;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      while (!fin && c <= 300) begin
         if (bus.valid && (!en_only || bus.clk_en)) bits = {bits[62:0], bus.out};
         if (bus.valid) nv++;
         if (bus.busy) nb++;
         if (bus.done) begin nd++; dc = c; fin = 1'b1; end
         tick();
         c++;
      end
      if (!fin) check("job_timeout", 64'd0, 64'd1);
      for (int k = 0; k < 3; k++) begin
         if (bus.busy) nb++;
         if (bus.done) nd++;
         tick();
      end
   endtask

   logic [63:0] bits;
   int nv, nb, nd, dc;

   initial begin
      bus.clk_en  = 1'b1;
      bus.start   = 1'b0;
      bus.pattern = 6'b000000;
      bus.reps    = 4'd0;
      #1;
      check("reset_outputs", {60'd0, bus.out, bus.valid, bus.busy, bus.done}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();

      // Single frame, clk_en tied high.
      run_job(6'b101100, 4'd1, 1'b0, bits, nv, nb, nd, dc);
`ifdef PATTERN_GEN_PARITY_EN
      check("t1_bits", bits, 64'b1011001);
      check("t1_nvalid", nv, 7);
      check("t1_done_cycle", dc, 8);
`else
      check("t1_bits", bits, 64'b101100);
      check("t1_nvalid", nv, 6);
      check("t1_done_cycle", dc, 7);
`endif
      check("t1_ndone", nd, 1);

      // Three repetitions separated by gaps.
      run_job(6'b101100, 4'd3, 1'b0, bits, nv, nb, nd, dc);
`ifdef PATTERN_GEN_PARITY_EN
      check("t2_bits", bits, 64'b1011001_1011001_1011001);
      check("t2_nbusy", nb, 25);
      check("t2_done_cycle", dc, 26);
`else
      check("t2_bits", bits, 64'b101100_101100_101100);
      check("t2_nbusy", nb, 22);
      check("t2_done_cycle", dc, 23);
`endif
      check("t2_ndone", nd, 1);

      // clk_en every 4th clock; accept on an edge with clk_en low.
      en_div = 4;
      while ((cyc % 4) != 1) tick();
      check("t3_start_with_en_low", {63'd0, bus.clk_en}, 64'd0);
      run_job(6'b101100, 4'd1, 1'b1, bits, nv, nb, nd, dc);
`ifdef PATTERN_GEN_PARITY_EN
      check("t3_bits", bits, 64'b1011001);
      check("t3_nvalid", nv, 27);
`else
      check("t3_bits", bits, 64'b101100);
      check("t3_nvalid", nv, 23);
`endif
      check("t3_ndone", nd, 1);
      en_div = 0;
      tick();

      // reps=0 runs once; starts mid-frame and during done are ignored.
      bus.pattern = 6'b011010;
      bus.reps    = 4'd0;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      bits = 64'd0; nv = 0; nd = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.valid) begin bits = {bits[62:0], bus.out}; nv++; end
         if (c == 2) begin bus.pattern = 6'b111111; bus.reps = 4'd5; bus.start = 1'b1; end
         if (bus.done) begin nd++; bus.start = 1'b1; end
         tick();
         bus.start = 1'b0;
      end
`ifdef PATTERN_GEN_PARITY_EN
      check("t4_bits", bits, 64'b0110101);
`else
      check("t4_bits", bits, 64'b011010);
`endif
      check("t4_ndone", nd, 1);
      check("t4_idle_busy", {63'd0, bus.busy}, 64'd0);

      // Asynchronous reset during bit 3, then a fresh frame.
      bus.pattern = 6'b110010;
      bus.reps    = 4'd1;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("t5_bit3_valid", {63'd0, bus.valid}, 64'd1);
      #2 reset = 1'b0;
      #1 check("t5_async_reset", {60'd0, bus.out, bus.valid, bus.busy, bus.done}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      run_job(6'b110010, 4'd1, 1'b0, bits, nv, nb, nd, dc);
`ifdef PATTERN_GEN_PARITY_EN
      check("t5_bits", bits, 64'b1100101);
`else
      check("t5_bits", bits, 64'b110010);
`endif
      check("t5_ndone", nd, 1);

      // Even-parity pattern.
      run_job(6'b100100, 4'd1, 1'b0, bits, nv, nb, nd, dc);
`ifdef PATTERN_GEN_PARITY_EN
      check("t6_bits", bits, 64'b1001000);
`else
      check("t6_bits", bits, 64'b100100);
`endif
      check("t6_ndone", nd, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial bit-pattern transmitter: latches a WIDTH-bit pattern and shifts it out MSB-first on a single-bit line. It runs one bit per `clk_en` strobe and can repeat the frame a programmable number of times, with idle gaps between frames. It drives the serial `in` input of the team's sequence-detector FSMs, both on the board and in their benches. A start/busy/done handshake lets a controller or testbench sequence frames.

## Interface
- WIDTH, 6: pattern length in bits (≥2).
- GAP, 2: idle bit-times between repeated frames (0 = back-to-back).
- REP_W, 4: width of the repeat-count input.
- DEFAULT_PATTERN, 6'b101100: reset value of the internal shift register. Not transmitted unless loaded.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous active-low reset (asserted when 0).
- clk_en  input  1  bit-time strobe; one transmitted bit per strobe.
- start  input  1  request a job; sampled every clk edge, accepted only in IDLE.
- pattern  input  WIDTH  frame bits; MSB sent first; latched on accept.
- reps  input  REP_W  frame repeat count; latched on accept; 0 treated as 1.
- out  output  1  serial data; 0 when not transmitting.
- valid  output  1  high while `out` carries a frame bit.
- busy  output  1  high from accept until the final bit completes.
- done  output  1  one-clk pulse after the job completes.

## Operation
- States: IDLE, SHIFT, GAP, PARITY (macro only), DONE.
- Reset (reset=0, async): state IDLE. out=0, valid=0, busy=0, done=0. Shift register=DEFAULT_PATTERN; bit/gap/rep counters=0.
- IDLE: out=0, valid=0, busy=0. On start=1 at a clk edge, independent of clk_en:
  - load shift register with `pattern`;
  - bit counter=0;
  - reps counter=max(reps,1);
  - go to SHIFT.
- SHIFT: out=shift register MSB, valid=1, busy=1. On each clk_en=1 edge:
  - bit counter<WIDTH-1: shift left by 1, bit counter+1.
  - Last bit: go to PARITY if enabled. Otherwise handle end of frame (below).
- End of frame:
  - reps counter>1: decrement it, then go to GAP (GAP>0), or reload `pattern` copy and re-enter SHIFT (GAP=0).
  - reps counter=1: go to DONE.
- Reload source: the pattern latched at accept. The live `pattern` input is ignored after accept.
- GAP: out=0, valid=0, busy=1. Counts GAP clk_en strobes. On the last one: reload, bit counter=0, go to SHIFT.
- DONE: done=1, busy=0, out=0 for exactly one clk cycle, then IDLE. start is ignored in DONE.
- start is ignored in SHIFT/GAP/PARITY/DONE. There is no abort; reset is the only abort.
- clk_en=0 freezes SHIFT, GAP and PARITY. All outputs hold.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Accept edge E0: first bit is on `out` with valid=1 immediately after E0.
- Each bit is held from its entry edge until the next clk_en=1 edge. With clk_en tied high, each bit lasts exactly 1 clk.
- Job length with clk_en=1: reps·F + (reps−1)·GAP clk cycles of busy, where F=WIDTH (or WIDTH+1 with parity). done pulses in the following cycle.
- Back-to-back jobs: start held high is accepted on the first IDLE edge, i.e. 2 clks after the final bit's edge.
- Reset deassertion is not synchronized internally; the top level provides a synchronized reset.

## Configuration
- PATTERN_GEN_PARITY_EN defined:
  - After the last data bit of each frame, PARITY state drives out = XOR-reduction of the latched pattern (even parity), with valid=1, for one clk_en strobe.
  - It then applies the end-of-frame rule; F=WIDTH+1.
- Undefined: PARITY state and its logic are absent; F=WIDTH.

## Test plan
- pattern=101100, reps=1, clk_en=1, start pulse at E0 → out=1,0,1,1,0,0 on cycles 1–6 with valid=1; done=1 on cycle 7; busy=0 from cycle 7.
- reps=3, GAP=2 → three 6-bit frames, each separated by 2 cycles of out=0/valid=0; busy for 22 cycles; a single done pulse.
- clk_en high every 4th clk, start asserted while clk_en=0 → accepted; each bit held 4 clks; sequence identical to test 1.
- reps=0 → exactly one frame. start re-pulsed mid-frame and during DONE → ignored; no second job.
- reset=0 asynchronously during bit 3 → out/valid/busy/done go 0 without a clk edge. After release plus start → full frame restarts from bit 0.
- With PATTERN_GEN_PARITY_EN, pattern=101100 → frame 1,0,1,1,0,0,1; pattern=100100 → frame ends with 0.
